// File: rtl/operand_select_stage_pkg.sv
// Shared types and default widths for the ALU operand-B select stage.
package opsel_pkg;

    typedef enum logic [1:0] {
        SRC_RDATA   = 2'd0,
        SRC_IMM     = 2'd1,
        SRC_FWD_EX  = 2'd2,
        SRC_FWD_MEM = 2'd3
    } src_sel_t;

    typedef enum logic [1:0] {
        EXT_ZERO  = 2'd0,
        EXT_SIGN  = 2'd1,
        EXT_UPPER = 2'd2,
        EXT_RSVD  = 2'd3
    } ext_mode_t;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } skid_state_t;

    localparam int unsigned DEFAULT_DATA_W = 32;
    localparam int unsigned DEFAULT_IMM_W  = 16;
    localparam int unsigned DEFAULT_TAG_W  = 5;
    localparam int unsigned DEFAULT_CNT_W  = 16;

endpackage

// File: rtl/operand_select_stage_if.sv
// Decode-to-execute operand bus: request side (sources, tag, flush) and registered result side.
interface operand_select_stage_if
    import opsel_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned IMM_W  = DEFAULT_IMM_W,
    parameter int unsigned TAG_W  = DEFAULT_TAG_W
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        src_sel;
    logic [1:0]        ext_mode;
    logic [DATA_W-1:0] rdata2;
    logic [IMM_W-1:0]  imm;
    logic [DATA_W-1:0] fwd_ex;
    logic [DATA_W-1:0] fwd_mem;
    logic [TAG_W-1:0]  in_tag;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [TAG_W-1:0]  out_tag;

    modport master (
        output in_valid, src_sel, ext_mode, rdata2, imm, fwd_ex, fwd_mem, in_tag, flush,
               out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, src_sel, ext_mode, rdata2, imm, fwd_ex, fwd_mem, in_tag, flush,
               out_ready,
        output in_ready, out_valid, out_data, out_tag
    );

endinterface

// File: rtl/operand_select_stage_imm_extend.sv
// Combinational immediate extender (zero / sign / upper placement), shared with the branch path.
module imm_extend
    import opsel_pkg::*;
#(
    parameter int unsigned IMM_W  = DEFAULT_IMM_W,
    parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
    input  logic [IMM_W-1:0]  imm,
    input  ext_mode_t         ext_mode,
    output logic [DATA_W-1:0] result
);

    if (IMM_W == DATA_W) begin : g_pass
        logic unused_mode;
        assign unused_mode = ^ext_mode;
        assign result      = imm;
    end else begin : g_ext
        always_comb begin
            result = {{(DATA_W-IMM_W){1'b0}}, imm};
            case (ext_mode)
                EXT_SIGN:  result = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
                EXT_UPPER: result = {imm, {(DATA_W-IMM_W){1'b0}}};
                default:   result = {{(DATA_W-IMM_W){1'b0}}, imm};
            endcase
        end
    end

endmodule

// File: rtl/operand_select_stage.sv
// Registered ALU operand-B select stage with valid/ready handshake, flush and stall counter.
// Define OPSEL_SKID_EN for a 1-entry skid buffer that registers in_ready.
module operand_select_stage
    import opsel_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned IMM_W  = DEFAULT_IMM_W,
    parameter int unsigned TAG_W  = DEFAULT_TAG_W,
    parameter int unsigned CNT_W  = DEFAULT_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    operand_select_stage_if.slave  bus,
    output logic [CNT_W-1:0]       stall_cnt
);

    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] sel_data;
    logic              in_ready;
    logic              out_valid;
    logic              xfer;
    logic [DATA_W-1:0] data_q, data_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [CNT_W-1:0]  stall_q;

    imm_extend #(
        .IMM_W  (IMM_W),
        .DATA_W (DATA_W)
    ) u_imm_extend (
        .imm      (bus.imm),
        .ext_mode (ext_mode_t'(bus.ext_mode)),
        .result   (imm_ext)
    );

    always_comb begin
        sel_data = bus.rdata2;
        case (src_sel_t'(bus.src_sel))
            SRC_IMM:     sel_data = imm_ext;
            SRC_FWD_EX:  sel_data = bus.fwd_ex;
            SRC_FWD_MEM: sel_data = bus.fwd_mem;
            default:     sel_data = bus.rdata2;
        endcase
    end

    assign xfer = bus.in_valid && in_ready;

`ifdef OPSEL_SKID_EN
    skid_state_t       state_q, state_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [TAG_W-1:0]  skid_tag_q, skid_tag_d;

    // in_ready depends only on registered state, never on out_ready.
    assign in_ready  = (state_q != StTwo);
    assign out_valid = (state_q != StEmpty);

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        tag_d       = tag_q;
        skid_data_d = skid_data_q;
        skid_tag_d  = skid_tag_q;
        if (bus.flush) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (xfer) begin
                        data_d  = sel_data;
                        tag_d   = bus.in_tag;
                        state_d = StOne;
                    end
                end
                StOne: begin
                    if (bus.out_ready) begin
                        if (xfer) begin
                            data_d = sel_data;
                            tag_d  = bus.in_tag;
                        end else begin
                            state_d = StEmpty;
                        end
                    end else if (xfer) begin
                        skid_data_d = sel_data;
                        skid_tag_d  = bus.in_tag;
                        state_d     = StTwo;
                    end
                end
                StTwo: begin
                    if (bus.out_ready) begin
                        data_d  = skid_data_q;
                        tag_d   = skid_tag_q;
                        state_d = StOne;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StEmpty;
            data_q      <= '0;
            tag_q       <= '0;
            skid_data_q <= '0;
            skid_tag_q  <= '0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            tag_q       <= tag_d;
            skid_data_q <= skid_data_d;
            skid_tag_q  <= skid_tag_d;
        end
    end
`else
    logic valid_q, valid_d;

    assign in_ready  = !valid_q || bus.out_ready;
    assign out_valid = valid_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        tag_d   = tag_q;
        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (xfer) begin
            valid_d = 1'b1;
            data_d  = sel_data;
            tag_d   = bus.in_tag;
        end else if (bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (out_valid && !bus.out_ready && !bus.flush && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = data_q;
    assign bus.out_tag   = tag_q;
    assign stall_cnt     = stall_q;

endmodule

// File: doc/operand_select_stage.md
Name: operand_select_stage

Overview:
- Registered ALU operand-B select stage, parametrised successor of the two-way register/immediate operand mux.
- Selects among register read data, an extended immediate, and two forwarding paths (EX and MEM results).
- Supports zero, sign and upper-placement extension modes.
- Registers the result behind a valid/ready handshake between decode and execute, with flush and a stall counter.

Parameters:
- DATA_W, 32, operand/output width.
- IMM_W, 16, immediate width; must satisfy 1 <= IMM_W <= DATA_W.
- TAG_W, 5, destination-register tag carried alongside the operand.
- CNT_W, 16, stall-counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  upstream operand request valid.
- in_ready  out  1  stage can accept a request.
- src_sel  in  2  0 RDATA, 1 IMM, 2 FWD_EX, 3 FWD_MEM.
- ext_mode  in  2  0 ZERO, 1 SIGN, 2 UPPER, 3 reserved.
- rdata2  in  DATA_W  register-file read port 2.
- imm  in  IMM_W  instruction immediate.
- fwd_ex  in  DATA_W  EX-stage result.
- fwd_mem  in  DATA_W  MEM-stage result.
- in_tag  in  TAG_W  destination tag.
- flush  in  1  discard held/in-flight operand.
- out_valid  out  1  registered operand valid.
- out_ready  in  1  execute stage accepts.
- out_data  out  DATA_W  registered operand.
- out_tag  out  TAG_W  registered tag.
- stall_cnt  out  CNT_W  saturating count of backpressure cycles.

Behaviour:
- Reset (rst_n=0 at a clk edge): out_valid=0, out_data=0, out_tag=0, stall_cnt=0, any skid entry invalid. Reset overrides flush and capture.
- Extension, applied only when src_sel=IMM:
  - ZERO: upper DATA_W-IMM_W bits are 0.
  - SIGN: replicate imm[IMM_W-1].
  - UPPER: imm placed in the top IMM_W bits, lower bits 0.
  - Mode 3 behaves as ZERO.
  - When IMM_W=DATA_W, all modes pass imm unchanged.
- ext_mode is ignored for the other three sources.
- Handshake and latency:
  - A transfer occurs when in_valid && in_ready.
  - The selected operand and in_tag appear on out_data/out_tag with out_valid=1 at the next edge, i.e. 1-cycle latency.
- While out_valid && !out_ready: out_data and out_tag hold stable and out_valid stays 1.
- Output consumed on out_valid && out_ready; out_valid drops unless a new transfer lands in the same cycle, in which case back-to-back throughput is 1/cycle.
- in_ready, without skid: in_ready = !out_valid || out_ready. This is combinational from out_ready.
- flush: at the next edge out_valid=0 and any skid entry is dropped. Flush wins over a simultaneous transfer, and the operand accepted in that cycle is discarded. out_data/out_tag are don't-care while out_valid=0 but hold their last value.
- stall_cnt:
  - Increments each cycle out_valid && !out_ready && !flush.
  - Saturates at all-ones and never wraps.
  - Cleared only by reset.
- No state machine beyond the valid bits; the skid variant has states EMPTY, ONE, TWO.

Optional Feature:
- Macro OPSEL_SKID_EN.
- Defined:
  - Adds a 1-entry skid buffer; in_ready is a registered signal, 1 when the skid is empty.
  - When out is stalled and an input transfer occurs, the input goes to the skid.
  - The skid drains into the output register on the next consume.
  - Ordering is preserved.
  - Flush clears both entries.
  - Throughput is 1/cycle with no combinational out_ready->in_ready path.
- Undefined: no skid; in_ready follows the combinational equation above.

Decomposition:
- Package opsel_pkg holds:
  - enum src_sel_t (SRC_RDATA, SRC_IMM, SRC_FWD_EX, SRC_FWD_MEM).
  - enum ext_mode_t (EXT_ZERO, EXT_SIGN, EXT_UPPER, EXT_RSVD).
  - Default width constants.
- One combinational sub-module, imm_extend (IMM_W, DATA_W, ext_mode -> DATA_W result), reused by the branch-offset path.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> out_valid=0, out_data=0, stall_cnt=0; first transfer after release appears one cycle later.
- Extension: imm=16'h8001 with IMM -> SIGN gives 32'hFFFF8001; ZERO gives 32'h00008001; UPPER gives 32'h80010000; mode 3 gives 32'h00008001.
- Source select: rdata2=32'h11, fwd_ex=32'h22, fwd_mem=32'h33 with src_sel 0/2/3 on consecutive cycles and out_ready=1 -> out_data 11, 22, 33 on the next three cycles, out_tag tracking.
- Backpressure: out_ready=0 for 4 cycles with a valid output -> out_data stable, stall_cnt +4. With CNT_W=2, 5 stall cycles -> stall_cnt=3.
- Flush collision: flush=1 in the same cycle as a transfer of 32'hDEAD -> out_valid=0 next cycle; 32'hDEAD is never emitted.
- Skid (OPSEL_SKID_EN): out_ready=0 while sending A then B -> A held and B in skid, in_ready=0; raise out_ready -> A then B on consecutive cycles, in_ready returns to 1.
